// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor and reset sequencer: qualifies the synchronised PLL lock,
// releases NUM_CH reset domains in staggered order, and retries or faults on timeout.
module pll_lock_supervisor #(
   parameter int unsigned NUM_CH           = 2,
   parameter int unsigned RST_PULSE_CYC    = 16,
   parameter int unsigned LOCK_STABLE_CYC  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYC = 65536,
   parameter int unsigned STAGGER_CYC      = 8,
   parameter int unsigned MAX_RETRY        = 3
) (
   input  logic              clkin,
   input  logic              reset_n,
   input  logic              pll_lock,
   input  logic              clr_fault,
   output logic              pll_reset,
   output logic [NUM_CH-1:0] ch_rst_n,
   output logic              locked,
   output logic              fault,
   output logic [3:0]        retry_cnt,
   output logic [7:0]        lock_loss_cnt
);

   localparam int unsigned REL_LAST = (NUM_CH - 1) * STAGGER_CYC;
   localparam int unsigned MAX_A    = (RST_PULSE_CYC > LOCK_STABLE_CYC) ? RST_PULSE_CYC : LOCK_STABLE_CYC;
   localparam int unsigned MAX_B    = (LOCK_TIMEOUT_CYC > REL_LAST + 1) ? LOCK_TIMEOUT_CYC : REL_LAST + 1;
   localparam int unsigned CNT_MAX  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned CNT_W    = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
   localparam logic [CNT_W-1:0] TOUT_LAST   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] REL_END     = CNT_W'(REL_LAST);
   localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_RELEASE,
      S_RUN,
      S_FAULT
   } state_t;

   state_t             state_q, state_nxt;
   logic [1:0]         sync_q;
   logic               lock_s;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   logic [CNT_W-1:0]   tcnt_q, tcnt_nxt;
   logic [3:0]         retry_nxt;
   logic [7:0]         loss_nxt;
   logic               timeout;
   logic               pll_reset_nxt;
   logic               locked_nxt;
   logic               fault_nxt;
   logic [NUM_CH-1:0]  ch_nxt;

   assign lock_s = sync_q[1];

   always_comb begin
      state_nxt = state_q;
      retry_nxt = retry_cnt;
      loss_nxt  = lock_loss_cnt;
      timeout   = ((state_q == S_WAIT_LOCK) || (state_q == S_STABLE)) && (tcnt_q == TOUT_LAST);

      case (state_q)
         S_RESET_PLL: if (cnt_q == RST_LAST) state_nxt = S_WAIT_LOCK;
         S_WAIT_LOCK: if (lock_s) state_nxt = S_STABLE;
         S_STABLE: begin
            if (!lock_s)                   state_nxt = S_WAIT_LOCK;
            else if (cnt_q == STABLE_LAST) state_nxt = S_RELEASE;
         end
         S_RELEASE: begin
            if (!lock_s)               state_nxt = S_RESET_PLL;
            else if (cnt_q == REL_END) state_nxt = S_RUN;
         end
         S_RUN:       if (!lock_s) state_nxt = S_RESET_PLL;
         S_FAULT: begin
            if (clr_fault) begin
               retry_nxt = '0;
               state_nxt = S_RESET_PLL;
            end
         end
         default:     state_nxt = S_RESET_PLL;
      endcase

      // Timeout overrides any lock-driven transition taken in the same cycle.
      if (timeout) begin
         retry_nxt = retry_cnt + 4'd1;
         state_nxt = (retry_nxt == RETRY_LIMIT) ? S_FAULT : S_RESET_PLL;
      end

      if (((state_q == S_RELEASE) || (state_q == S_RUN)) && !lock_s && (lock_loss_cnt != 8'hFF))
         loss_nxt = lock_loss_cnt + 8'd1;

      if ((state_nxt == S_RUN) && (state_q != S_RUN))
         retry_nxt = '0;

      if (state_nxt != state_q)
         cnt_nxt = '0;
      else if ((state_q == S_RESET_PLL) || (state_q == S_STABLE) || (state_q == S_RELEASE))
         cnt_nxt = cnt_q + 1'b1;
      else
         cnt_nxt = cnt_q;

      // tcnt survives STABLE -> WAIT_LOCK bounces; only a fresh pulse restarts it.
      if ((state_nxt == S_WAIT_LOCK) || (state_nxt == S_STABLE))
         tcnt_nxt = ((state_q == S_WAIT_LOCK) || (state_q == S_STABLE)) ? tcnt_q + 1'b1 : '0;
      else
         tcnt_nxt = '0;

      pll_reset_nxt = (state_nxt == S_RESET_PLL) || (state_nxt == S_FAULT);
      locked_nxt    = (state_nxt == S_RUN);
      fault_nxt     = (state_nxt == S_FAULT);

      ch_nxt = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (state_nxt == S_RUN)
            ch_nxt[i] = 1'b1;
         else if (state_nxt == S_RELEASE)
            ch_nxt[i] = ch_rst_n[i] | (cnt_nxt >= CNT_W'(i * STAGGER_CYC));
      end
   end

   always_ff @(posedge clkin) begin
      if (!reset_n) begin
         state_q       <= S_RESET_PLL;
         sync_q        <= '0;
         cnt_q         <= '0;
         tcnt_q        <= '0;
         pll_reset     <= 1'b1;
         ch_rst_n      <= '0;
         locked        <= 1'b0;
         fault         <= 1'b0;
         retry_cnt     <= '0;
         lock_loss_cnt <= '0;
      end else begin
         state_q       <= state_nxt;
         sync_q        <= {sync_q[0], pll_lock};
         cnt_q         <= cnt_nxt;
         tcnt_q        <= tcnt_nxt;
         pll_reset     <= pll_reset_nxt;
         ch_rst_n      <= ch_nxt;
         locked        <= locked_nxt;
         fault         <= fault_nxt;
         retry_cnt     <= retry_nxt;
         lock_loss_cnt <= loss_nxt;
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: per-cycle vector table for bring-up and
// lock loss, plus hand-written glitch, timeout/fault, reset and saturation sequences.
module tb_pll_lock_supervisor;

   logic       clkin = 1'b0;
   logic       reset_n = 1'b0;
   logic       pll_lock = 1'b0;
   logic       clr_fault = 1'b0;
   logic       pll_reset;
   logic [2:0] ch_rst_n;
   logic       locked;
   logic       fault;
   logic [3:0] retry_cnt;
   logic [7:0] lock_loss_cnt;

   int tests = 0;
   int fails = 0;

   pll_lock_supervisor #(
      .NUM_CH(3),
      .RST_PULSE_CYC(4),
      .LOCK_STABLE_CYC(8),
      .LOCK_TIMEOUT_CYC(64),
      .STAGGER_CYC(2),
      .MAX_RETRY(2)
   ) dut (
      .clkin(clkin),
      .reset_n(reset_n),
      .pll_lock(pll_lock),
      .clr_fault(clr_fault),
      .pll_reset(pll_reset),
      .ch_rst_n(ch_rst_n),
      .locked(locked),
      .fault(fault),
      .retry_cnt(retry_cnt),
      .lock_loss_cnt(lock_loss_cnt)
   );

   always #5 clkin = ~clkin;

   typedef struct {
      int unsigned n;
      logic        rst_n, lock, clr;
      logic        pr;
      logic [2:0]  ch;
      logic        lk, flt;
      logic [3:0]  rc;
      logic [7:0]  lc;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input int unsigned n, input logic rst_n, input logic lock, input logic clr,
                      input logic pr, input logic [2:0] ch, input logic lk, input logic flt,
                      input logic [3:0] rc, input logic [7:0] lc);
      vec_t v;
      v.n = n; v.rst_n = rst_n; v.lock = lock; v.clr = clr;
      v.pr = pr; v.ch = ch; v.lk = lk; v.flt = flt; v.rc = rc; v.lc = lc;
      tbl.push_back(v);
   endtask

   task automatic step();
      @(posedge clkin);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int pack_out();
      return int'({pll_reset, ch_rst_n, locked, fault, retry_cnt, lock_loss_cnt});
   endfunction

   function automatic int pack_exp(input vec_t v);
      return int'({v.pr, v.ch, v.lk, v.flt, v.rc, v.lc});
   endfunction

   task automatic do_reset();
      reset_n = 1'b0; pll_lock = 1'b0; clr_fault = 1'b0;
      step();
      step();
      reset_n = 1'b1;
   endtask

   initial begin
      int edge_idx;
      int rise0, rise1, nrise, fault_e, ch0_e, pr_seen;
      logic prev_pr;
      bit got;

      // nominal bring-up, lock loss in RUN, full re-sequence
      add(1,  0,0,0, 1,3'b000,0,0,0,0);
      add(3,  1,0,0, 1,3'b000,0,0,0,0);
      add(10, 1,0,0, 0,3'b000,0,0,0,0);
      add(10, 1,1,0, 0,3'b000,0,0,0,0);
      add(2,  1,1,0, 0,3'b001,0,0,0,0);
      add(2,  1,1,0, 0,3'b011,0,0,0,0);
      add(1,  1,1,0, 0,3'b111,0,0,0,0);
      add(3,  1,1,0, 0,3'b111,1,0,0,0);
      add(2,  1,0,0, 0,3'b111,1,0,0,0);
      add(4,  1,0,0, 1,3'b000,0,0,0,1);
      add(1,  1,0,0, 0,3'b000,0,0,0,1);
      add(10, 1,1,0, 0,3'b000,0,0,0,1);
      add(2,  1,1,0, 0,3'b001,0,0,0,1);
      add(2,  1,1,0, 0,3'b011,0,0,0,1);
      add(1,  1,1,0, 0,3'b111,0,0,0,1);
      add(2,  1,1,0, 0,3'b111,1,0,0,1);

      foreach (tbl[r]) begin
         for (int unsigned k = 0; k < tbl[r].n; k++) begin
            reset_n = tbl[r].rst_n; pll_lock = tbl[r].lock; clr_fault = tbl[r].clr;
            step();
            check($sformatf("vec%0d.%0d", r, k), pack_out(), pack_exp(tbl[r]));
         end
      end

      // one-cycle lock drop in RUN, then reset when ch_rst_n reaches 011
      pll_lock = 1'b0;
      step();
      pll_lock = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
         step();
         if (ch_rst_n == 3'b011) got = 1'b1;
      end
      check("midrel_reached", int'(got), 1);
      check("midrel_loss", int'(lock_loss_cnt), 2);
      reset_n = 1'b0;
      step();
      check("midrel_reset", pack_out(), int'({1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0}));

      // lock glitch during STABLE: release moves from edge 12 to edge 20
      do_reset();
      ch0_e = -1; pr_seen = 0;
      for (int e = 0; e < 40; e++) begin
         pll_lock = (e != 9);
         step();
         if (ch0_e < 0 && ch_rst_n[0]) ch0_e = e;
         if (e >= 3 && pll_reset) pr_seen++;
      end
      check("glitch_release_edge", ch0_e, 20);
      check("glitch_no_pll_reset", pr_seen, 0);
      check("glitch_retry", int'(retry_cnt), 0);
      check("glitch_locked", int'(locked), 1);

      // timeout to fault, clr_fault ignored outside FAULT
      do_reset();
      prev_pr = 1'b1; nrise = 0; rise0 = -1; rise1 = -1; fault_e = -1;
      for (int e = 0; e < 200; e++) begin
         clr_fault = (e == 100);
         step();
         if (pll_reset && !prev_pr) begin
            if (nrise == 0) rise0 = e; else if (nrise == 1) rise1 = e;
            nrise++;
         end
         prev_pr = pll_reset;
         if (fault_e < 0 && fault) fault_e = e;
         if (e == 100) check("clr_outside_fault", int'(retry_cnt), 1);
      end
      clr_fault = 1'b0;
      check("tout_rises", nrise, 2);
      check("tout_first", rise0, 67);
      check("tout_period", rise1 - rise0, 68);
      check("fault_edge", fault_e, 135);
      check("fault_state", pack_out(), int'({1'b1, 3'b000, 1'b0, 1'b1, 4'd2, 8'd0}));
      clr_fault = 1'b1;
      step();
      clr_fault = 1'b0;
      check("clr_fault", pack_out(), int'({1'b1, 3'b000, 1'b0, 1'b0, 4'd0, 8'd0}));
      step(); step(); step();
      check("clr_pulse_hi", int'(pll_reset), 1);
      step();
      check("clr_pulse_lo", int'(pll_reset), 0);

      // lock-loss counter saturation
      do_reset();
      pll_lock = 1'b1;
      for (int k = 0; k < 260; k++) begin
         got = 1'b0;
         for (int i = 0; i < 100 && !got; i++) begin
            step();
            if (ch_rst_n[0]) got = 1'b1;
         end
         if (!got) check($sformatf("sat_up%0d", k), 0, 1);
         pll_lock = 1'b0;
         step();
         pll_lock = 1'b1;
         got = 1'b0;
         for (int i = 0; i < 10 && !got; i++) begin
            if (!ch_rst_n[0]) got = 1'b1;
            else step();
         end
         if (!got) check($sformatf("sat_down%0d", k), 0, 1);
         if (k == 0 || k == 99 || k == 254 || k == 255 || k == 259)
            check($sformatf("sat_cnt%0d", k), int'(lock_loss_cnt), (k + 1 > 255) ? 255 : k + 1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Parametrised lock supervisor and reset sequencer for the PLL wrapper. Runs on the PLL reference clock and drives the PLL reset pulse. It synchronises and qualifies the PLL lock, then releases NUM_CH downstream reset domains in staggered order. It retries on lock timeout, latches a fault after MAX_RETRY failures, and re-sequences automatically on lock loss.

## Interface
- NUM_CH, 2: number of downstream reset channels (1..16).
- RST_PULSE_CYC, 16: PLL reset pulse length in clkin cycles (≥1).
- LOCK_STABLE_CYC, 1024: consecutive synchronised-lock-high cycles required before release (≥1).
- LOCK_TIMEOUT_CYC, 65536: cycles allowed from end of PLL reset pulse to qualified lock (> LOCK_STABLE_CYC).
- STAGGER_CYC, 8: spacing between successive channel releases (≥1).
- MAX_RETRY, 3: timeouts tolerated before fault (1..15).

- clkin  in  1  reference clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- pll_lock  in  1  raw PLL lock, asynchronous to clkin.
- clr_fault  in  1  single-cycle fault clear, honoured only in FAULT.
- pll_reset  out  1  active-high PLL reset, registered.
- ch_rst_n  out  NUM_CH  per-channel active-low resets, registered.
- locked  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_cnt  out  4  timeouts since last RUN or clr_fault.
- lock_loss_cnt  out  8  saturating count of lock losses after RUN.

## Operation
- pll_lock passes through a 2-flop synchroniser to give lock_s. Every use below refers to lock_s.
- One counter, cnt, of width $clog2(max parameter)+1 is cleared on every state entry. A separate timeout counter, tcnt, is cleared on entry to WAIT_LOCK and runs through WAIT_LOCK and STABLE.
- RESET_PLL: pll_reset=1 and ch_rst_n all 0. lock_s is ignored. At cnt=RST_PULSE_CYC-1, go to WAIT_LOCK.
- WAIT_LOCK: pll_reset=0. If lock_s=1, go to STABLE. Timeout applies here (see below).
- STABLE: cnt increments while lock_s=1.
  - If lock_s=0, return to WAIT_LOCK without clearing tcnt.
  - At cnt=LOCK_STABLE_CYC-1 with lock_s=1, go to RELEASE.
- Timeout rule: when tcnt=LOCK_TIMEOUT_CYC-1 in WAIT_LOCK or STABLE, increment retry_cnt.
  - If the new value equals MAX_RETRY, go to FAULT.
  - Otherwise, go to RESET_PLL.
- RELEASE: ch_rst_n[i] goes high once cnt reaches i*STAGGER_CYC, and stays high. When cnt=(NUM_CH-1)*STAGGER_CYC, go to RUN.
- RUN: locked=1, all ch_rst_n=1, retry_cnt cleared on entry.
- Lock loss: lock_s=0 in RELEASE or RUN triggers all of the following:
  - go to RESET_PLL;
  - lock_loss_cnt increments, saturating at 255;
  - ch_rst_n goes all 0 and locked goes 0 on the next edge.
- FAULT: pll_reset=1, ch_rst_n all 0, fault=1. clr_fault=1 clears retry_cnt and goes to RESET_PLL. Otherwise FAULT holds indefinitely.
- Simultaneous events:
  - timeout and lock_s rising in the same cycle: the timeout wins;
  - stable completion and timeout in the same cycle: the timeout wins;
  - clr_fault outside FAULT: ignored.

## Timing
- Reset values: pll_reset=1, ch_rst_n=0, locked=0, fault=0, retry_cnt=0, lock_loss_cnt=0, synchroniser flops 0, state RESET_PLL, cnt=0.
- The first edge with reset_n=1 is cycle 0 of RESET_PLL. pll_reset stays high for RST_PULSE_CYC cycles after reset release, then falls.
- Lock latency:
  - pll_lock rising to lock_s rising: 2 edges.
  - lock_s rising to ch_rst_n[0] rising: LOCK_STABLE_CYC+1 edges.
  - ch_rst_n[i] rises STAGGER_CYC edges after ch_rst_n[i-1].
  - locked rises 1 edge after ch_rst_n[NUM_CH-1].
- Timeout-retry period: RST_PULSE_CYC+LOCK_TIMEOUT_CYC cycles.
- Lock-loss response: pll_lock falling to ch_rst_n all 0 is 3 edges (2 for synchronisation, 1 for the registered output).
- reset_n low at any state, including mid-RELEASE or FAULT, forces all reset values on the next edge.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
Parameters for all tests: NUM_CH=3, RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=64, STAGGER_CYC=2, MAX_RETRY=2.

- **Nominal bring-up.** Release reset_n, then raise pll_lock 10 cycles after pll_reset falls.
  - pll_reset is high for exactly 4 cycles.
  - ch_rst_n goes 001, then 011, then 111 at 2-cycle spacing, starting 11 edges after pll_lock rises.
  - locked=1 one edge later; retry_cnt=0.
- **Lock glitch during STABLE.** Drop pll_lock for 1 cycle, 5 cycles into STABLE.
  - The stable count restarts, and release is delayed by the glitch position plus synchronisation.
  - No retry is counted and no pll_reset pulse occurs.
- **Timeout to fault.** Hold pll_lock at 0.
  - pll_reset pulses twice, 68 cycles apart.
  - On the second timeout: fault=1, retry_cnt=2, pll_reset held 1.
  - Pulse clr_fault: retry_cnt=0 and a new 4-cycle pll_reset pulse starts.
- **Lock loss in RUN.** Drop pll_lock while in RUN.
  - 3 edges later: ch_rst_n=000, locked=0, lock_loss_cnt 0→1.
  - pll_reset is then high for 4 cycles.
  - Full re-sequence follows once lock returns.
- **Reset mid-RELEASE.** Assert reset_n low when ch_rst_n=011.
  - Next edge: all outputs at reset values, including lock_loss_cnt=0.
- **Lock-loss counter saturation.** Force 260 lock losses.
  - lock_loss_cnt stops at 255 and does not wrap.
